control_avance_pipeline: RTL and testbench

Pipeline advance controller for the 5-stage MIPS core. It consumes the stall request from the hazard detection unit, the ID-stage branch/jump resolution and the HALT decode. From these it drives the PC and IF/ID write enables, the IF/ID flush and the ID/EX bubble insert. It also implements run, single-step and halt-drain sequencing for the debug unit, and keeps a saturating count of stall cycles for debug readout.

---
 rtl/control_avance_pipeline_pkg.sv | 25 ++
 rtl/control_avance_pipeline_contador_saturado.sv | 33 +++
 rtl/control_avance_pipeline.sv | 146 ++++++++++++++
 tb/tb_control_avance_pipeline.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_avance_pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : control_avance_pipeline_pkg
// Description : Shared definitions for the pipeline advance controller.
//               Holds the 3-bit FSM state encoding and the default number
//               of drain cycles (EX, MEM, WB) that follow a HALT.
// Revision    : 1.0 - initial release
// ============================================================================
package control_avance_pipeline_pkg;

    // Default drain length: the HALT still has to cross EX, MEM and WB.
    localparam int unsigned c_DRAIN_CYCLES_DEFAULT = 3;

    // FSM state encoding
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_RUN       = 3'd1;
    localparam state_t ST_STEP_WAIT = 3'd2;
    localparam state_t ST_STEP      = 3'd3;
    localparam state_t ST_DRAIN     = 3'd4;
    localparam state_t ST_HALTED    = 3'd5;

endpackage
`default_nettype wire

// File: rtl/control_avance_pipeline_contador_saturado.sv
`default_nettype none
// ============================================================================
// Module      : contador_saturado
// Description : Up-counter that sticks at all-ones instead of wrapping.
//   i_clk   - clock, rising edge
//   i_rst   - synchronous active-high reset, clears the count
//   i_en    - count enable, one increment per enabled edge
//   o_count - current count (CNT_W bits)
// Revision    : 1.0 - initial release
// ============================================================================
module contador_saturado #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/control_avance_pipeline.sv
`default_nettype none
// ============================================================================
// Module      : control_avance_pipeline
// Description : Pipeline advance controller for the 5-stage MIPS core.
//               Combines hazard stall, ID-stage branch resolution and HALT
//               decode into PC / IF-ID enables, IF-ID flush and ID-EX bubble.
//               Sequences run, single-step and halt-drain for the debug unit
//               and keeps a saturating stall-cycle count.
//   i_clk / i_reset      - clock, synchronous active-high reset
//   i_run                - leave IDLE and start execution
//   i_debug_mode         - sampled in IDLE: 1 = step mode, 0 = continuous
//   i_debug_step         - one-cycle pulse, advance one clock (step mode)
//   i_stall              - hazard unit stall request
//   i_branch_taken       - branch/jump resolved taken in ID
//   i_halt_ID            - HALT instruction sits in ID
//   o_pc_write           - PC register enable
//   o_if_id_write        - IF/ID register enable
//   o_if_id_flush        - load NOP into IF/ID on next edge
//   o_id_ex_bubble       - zero ID/EX control fields on next edge
//   o_halted             - registered, pipeline empty after HALT
//   o_stall_count        - saturating count of stall cycles
// Revision    : 1.0 - initial release
// ============================================================================
module control_avance_pipeline
    import control_avance_pipeline_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = c_DRAIN_CYCLES_DEFAULT,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_run,
    input  logic             i_debug_mode,
    input  logic             i_debug_step,
    input  logic             i_stall,
    input  logic             i_branch_taken,
    input  logic             i_halt_ID,
    output logic             o_pc_write,
    output logic             o_if_id_write,
    output logic             o_if_id_flush,
    output logic             o_id_ex_bubble,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_stall_count
);

    localparam int unsigned c_DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [c_DW-1:0] c_DRAIN_LOAD = c_DW'(DRAIN_CYCLES - 1);

    state_t          r_state;
    logic [c_DW-1:0] r_drain_cnt;
    logic            r_halted;

    logic w_advancing;
    logic w_accept_halt;
    logic w_count_en;

    assign w_advancing   = (r_state == ST_RUN) || (r_state == ST_STEP);
    // A stalled HALT stays parked in ID; drain starts only once it moves on.
    assign w_accept_halt = w_advancing && i_halt_ID && !i_stall;
    assign w_count_en    = w_advancing && i_stall;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= '0;
            r_halted    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_run) begin
                        r_state <= i_debug_mode ? ST_STEP_WAIT : ST_RUN;
                    end
                end
                ST_STEP_WAIT: begin
                    if (i_debug_step) begin
                        r_state <= ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (w_accept_halt) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= c_DRAIN_LOAD;
                    end
                end
                ST_STEP: begin
                    // One-cycle state: any step pulse seen here is dropped.
                    if (w_accept_halt) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= c_DRAIN_LOAD;
                    end else begin
                        r_state <= ST_STEP_WAIT;
                    end
                end
                ST_DRAIN: begin
                    // Drain runs free of step mode so the pipe always empties.
                    if (r_drain_cnt == '0) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - c_DW'(1);
                    end
                end
                ST_HALTED: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_drain_cnt <= '0;
                    r_halted    <= 1'b0;
                end
            endcase
        end
    end

    // Mealy outputs: zero latency from the hazard / branch / halt inputs.
    always_comb begin
        o_pc_write     = 1'b0;
        o_if_id_write  = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_bubble = 1'b0;
        if (w_advancing) begin
            o_pc_write     = !i_stall && !i_halt_ID;
            o_if_id_write  = !i_stall && !i_halt_ID;
            // Stall and halt both outrank a taken branch.
            o_if_id_flush  = i_branch_taken && !i_stall && !i_halt_ID;
            o_id_ex_bubble = i_stall;
        end else if (r_state == ST_DRAIN) begin
            // Freeze fetch and push NOPs in behind the HALT.
            o_if_id_flush  = 1'b1;
            o_id_ex_bubble = 1'b1;
        end
    end

    assign o_halted = r_halted;

    contador_saturado #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_reset),
        .i_en    (w_count_en),
        .o_count (o_stall_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_control_avance_pipeline.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_avance_pipeline
// Description : Self-checking bench for control_avance_pipeline. Directed
//               scenarios plus randomized traffic, compared against a
//               behavioural model of the controller's run/step/drain rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_avance_pipeline;

    localparam int CNT_W  = 4;
    localparam int DRAIN  = 3;
    localparam int SAT    = (1 << CNT_W) - 1;

    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_WAIT = 2;
    localparam int P_STEP = 3;
    localparam int P_DRN  = 4;
    localparam int P_HALT = 5;

    logic clk = 1'b0;
    logic reset, run, debug_mode, debug_step, stall, branch_taken, halt_id;
    logic pc_write, if_id_write, if_id_flush, id_ex_bubble, halted;
    logic [CNT_W-1:0] stall_count;
    logic [4:0] outs;

    int checks   = 0;
    int failures = 0;

    int m_phase;
    int m_drain_left;
    int m_stalls;

    always #5 clk = ~clk;

    assign outs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, halted};

    control_avance_pipeline #(
        .DRAIN_CYCLES (DRAIN),
        .CNT_W        (CNT_W)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_run          (run),
        .i_debug_mode   (debug_mode),
        .i_debug_step   (debug_step),
        .i_stall        (stall),
        .i_branch_taken (branch_taken),
        .i_halt_ID      (halt_id),
        .o_pc_write     (pc_write),
        .o_if_id_write  (if_id_write),
        .o_if_id_flush  (if_id_flush),
        .o_id_ex_bubble (id_ex_bubble),
        .o_halted       (halted),
        .o_stall_count  (stall_count)
    );

    // Expected {pc_write, if_id_write, if_id_flush, id_ex_bubble, halted}
    function automatic logic [4:0] model_out();
        logic [4:0] r;
        r = 5'b00000;
        if (m_phase == P_RUN || m_phase == P_STEP) begin
            if (stall) r = 5'b00010;
            else if (halt_id) r = 5'b00000;
            else if (branch_taken) r = 5'b11100;
            else r = 5'b11000;
        end else if (m_phase == P_DRN) begin
            r = 5'b00110;
        end else if (m_phase == P_HALT) begin
            r = 5'b00001;
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] model_cnt();
        return CNT_W'(m_stalls);
    endfunction

    // Effect of one rising edge, given the inputs currently applied.
    task automatic model_clock();
        if (reset) begin
            m_phase = P_IDLE; m_drain_left = 0; m_stalls = 0;
        end else begin
            case (m_phase)
                P_IDLE: if (run) m_phase = debug_mode ? P_WAIT : P_RUN;
                P_WAIT: if (debug_step) m_phase = P_STEP;
                P_RUN, P_STEP: begin
                    if (stall && m_stalls < SAT) m_stalls++;
                    if (halt_id && !stall) begin
                        m_phase = P_DRN; m_drain_left = DRAIN;
                    end else if (m_phase == P_STEP) begin
                        m_phase = P_WAIT;
                    end
                end
                P_DRN: begin
                    m_drain_left--;
                    if (m_drain_left == 0) m_phase = P_HALT;
                end
                default: ;
            endcase
        end
    endtask

    task automatic set_in(input logic rs, rn, md, sp, sl, br, ht);
        reset = rs; run = rn; debug_mode = md; debug_step = sp;
        stall = sl; branch_taken = br; halt_id = ht;
    endtask

    task automatic advance();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic do_reset();
        set_in(1, 0, 0, 0, 0, 0, 0);
        advance();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            set_in(1, 0, 0, 0, 0, 0, 0);
            advance();
            set_in(1, 1, 0, 0, 1, 1, 1);
            #4;
            checks++;
            if (outs !== 5'b00000) begin
                failures++;
                $display("FAIL reset_outs outs=%b expected=%b", outs, 5'b00000);
            end
            checks++;
            if (stall_count !== '0) begin
                failures++;
                $display("FAIL reset_count got=%0d expected=0", stall_count);
            end
        end
        advance();
    endtask

    task automatic test_run();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            set_in(0, 1, 0, 0, 0, 0, 0);
            #4;
            checks++;
            if (outs !== model_out()) begin
                failures++;
                $display("FAIL run_model cyc=%0d outs=%b expected=%b", i, outs, model_out());
            end
            advance();
        end
        set_in(0, 1, 0, 0, 0, 0, 0);
        #4;
        checks++;
        if (outs !== 5'b11000 || stall_count !== '0) begin
            failures++;
            $display("FAIL run_enables outs=%b cnt=%0d expected=11000 cnt=0", outs, stall_count);
        end
    endtask

    task automatic test_stall_branch();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 0, 0, 1, 1, 0);
            #4;
            checks++;
            if (outs !== 5'b00010 || outs !== model_out()) begin
                failures++;
                $display("FAIL stall_outs cyc=%0d outs=%b expected=00010", i, outs);
            end
            advance();
        end
        set_in(0, 1, 0, 0, 0, 1, 0);
        #4;
        checks++;
        if (stall_count !== 4'd3) begin
            failures++;
            $display("FAIL stall_count got=%0d expected=3", stall_count);
        end
        checks++;
        if (outs !== 5'b11100 || outs !== model_out()) begin
            failures++;
            $display("FAIL branch_after_stall outs=%b expected=11100", outs);
        end
        advance();
    endtask

    task automatic test_halt_drain();
        set_in(0, 1, 0, 0, 0, 1, 1);
        #4;
        checks++;
        if (outs !== 5'b00000 || outs !== model_out()) begin
            failures++;
            $display("FAIL halt_accept outs=%b expected=00000", outs);
        end
        advance();
        for (int i = 0; i < DRAIN; i++) begin
            set_in(0, 1, 0, 0, 0, 0, 0);
            #4;
            checks++;
            if (outs !== 5'b00110 || outs !== model_out()) begin
                failures++;
                $display("FAIL drain_outs cyc=%0d outs=%b expected=00110", i, outs);
            end
            advance();
        end
        for (int i = 0; i < 4; i++) begin
            set_in(0, logic'(i[0]), 0, 1, 0, 1, logic'(i[1]));
            #4;
            checks++;
            if (outs !== 5'b00001 || outs !== model_out()) begin
                failures++;
                $display("FAIL halted_hold cyc=%0d outs=%b expected=00001", i, outs);
            end
            advance();
        end
    endtask

    task automatic test_step();
        int pc_highs;
        pc_highs = 0;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            set_in(0, 1, 1, (i == 2 || i == 3 || i == 7), 0, 0, 0);
            #4;
            if (pc_write === 1'b1) pc_highs++;
            checks++;
            if (outs !== model_out()) begin
                failures++;
                $display("FAIL step_model cyc=%0d outs=%b expected=%b", i, outs, model_out());
            end
            advance();
        end
        checks++;
        if (pc_highs != 2) begin
            failures++;
            $display("FAIL step_pc_cycles got=%0d expected=2", pc_highs);
        end
    endtask

    task automatic test_halt_stall();
        int edges;
        do_reset();
        set_in(0, 1, 0, 0, 0, 0, 0);
        advance();
        for (int i = 0; i < 2; i++) begin
            set_in(0, 1, 0, 0, 1, 0, 1);
            #4;
            checks++;
            if (outs !== 5'b00010 || outs !== model_out()) begin
                failures++;
                $display("FAIL halt_stall_outs cyc=%0d outs=%b expected=00010", i, outs);
            end
            advance();
        end
        set_in(0, 1, 0, 0, 0, 0, 1);
        edges = 0;
        while (halted !== 1'b1 && edges < 10) begin
            #4;
            checks++;
            if (outs !== model_out()) begin
                failures++;
                $display("FAIL halt_stall_drain cyc=%0d outs=%b expected=%b", edges, outs, model_out());
            end
            advance();
            edges++;
            set_in(0, 1, 0, 0, 0, 0, 0);
        end
        checks++;
        if (edges != DRAIN + 1) begin
            failures++;
            $display("FAIL halt_latency edges=%0d expected=%0d", edges, DRAIN + 1);
        end
        checks++;
        if (stall_count !== 4'd2) begin
            failures++;
            $display("FAIL halt_stall_count got=%0d expected=2", stall_count);
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        set_in(0, 1, 0, 0, 1, 0, 0);
        advance();
        advance();
        set_in(0, 1, 0, 0, 0, 0, 1);
        advance();
        set_in(0, 1, 0, 0, 0, 0, 0);
        advance();
        set_in(1, 1, 0, 0, 0, 0, 0);
        #4;
        checks++;
        if (outs !== 5'b00110 || outs !== model_out()) begin
            failures++;
            $display("FAIL mid_drain_outs outs=%b expected=00110", outs);
        end
        advance();
        set_in(0, 0, 0, 0, 1, 1, 1);
        #4;
        checks++;
        if (outs !== 5'b00000 || stall_count !== '0) begin
            failures++;
            $display("FAIL reset_mid_drain outs=%b cnt=%0d expected=00000 cnt=0", outs, stall_count);
        end
        advance();
    endtask

    task automatic test_saturation();
        do_reset();
        set_in(0, 1, 0, 0, 0, 0, 0);
        advance();
        for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
            set_in(0, 1, 0, 0, 1, 0, 0);
            #4;
            checks++;
            if (stall_count !== model_cnt() || outs !== model_out()) begin
                failures++;
                $display("FAIL sat_model cyc=%0d cnt=%0d outs=%b expected cnt=%0d outs=%b",
                         i, stall_count, outs, model_cnt(), model_out());
            end
            advance();
        end
        set_in(0, 1, 0, 0, 0, 0, 0);
        #4;
        checks++;
        if (stall_count !== 4'd15) begin
            failures++;
            $display("FAIL sat_hold got=%0d expected=15", stall_count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom_range(63) == 0), $urandom_range(1), $urandom_range(1),
                   ($urandom_range(3) == 0), ($urandom_range(2) == 0),
                   ($urandom_range(2) == 0), ($urandom_range(7) == 0));
            #4;
            checks++;
            if (outs !== model_out()) begin
                failures++;
                $display("FAIL rand_outs cyc=%0d outs=%b expected=%b", i, outs, model_out());
            end
            checks++;
            if (stall_count !== model_cnt()) begin
                failures++;
                $display("FAIL rand_count cyc=%0d got=%0d expected=%0d", i, stall_count, model_cnt());
            end
            advance();
        end
    endtask

    initial begin
        m_phase = P_IDLE; m_drain_left = 0; m_stalls = 0;
        set_in(1, 0, 0, 0, 0, 0, 0);
        #1;
        advance();
        test_reset();
        test_run();
        test_stall_branch();
        test_halt_drain();
        test_step();
        test_halt_stall();
        test_reset_mid_drain();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
